// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory.
// Covers access-size encodings, FSM states and lane byte-enable generation.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned MAX_BYTES = 32;

  // Byte enables for an access of size sz starting at byte lane 'lane' in a word of nbytes.
  function automatic logic [MAX_BYTES-1:0] lane_be(input size_t sz, input int unsigned lane,
                                                   input int unsigned nbytes);
    logic [MAX_BYTES-1:0] be;
    be = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      case (sz)
        SZ_BYTE: be[i] = (i == lane);
        SZ_HALF: be[i] = (i == lane) || (i == lane + 1);
        SZ_WORD: be[i] = (i < nbytes);
        default: be[i] = 1'b0;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned BYTES  = DATA_W / 8,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [BYTES-1:0]  be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_hs.sv
// Handshaked data memory: ready/valid request, held response, byte/half/word
// accesses with load extension, configurable wait states and error reporting.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  size_t             sz, size_q;
  logic [LANE_W-1:0] lane, lane_q;
  logic [ADDR_W-1:0] word_idx;
  logic              req_err, accept;
  logic              write_q, err_q, sgn_q;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] wrep, rd_word, sh, load;

  assign sz       = size_t'(req_size);
  assign lane     = req_addr[LANE_W-1:0];
  assign word_idx = req_addr >> LANE_W;
  assign req_err  = (sz == SZ_BAD) || (sz == SZ_HALF && req_addr[0]) ||
                    (sz == SZ_WORD && |lane) || (word_idx >= ADDR_W'(DEPTH));

  // Gated by reset so the block never advertises readiness while held in reset.
  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign be         = BYTES'(lane_be(sz, 32'(lane), BYTES));

  always_comb begin
    case (sz)
      SZ_BYTE: wrep = {BYTES{req_wdata[7:0]}};
      SZ_HALF: wrep = {(BYTES/2){req_wdata[15:0]}};
      default: wrep = req_wdata;
    endcase
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clock(clock),
    .wr_en(accept && req_write && !req_err),
    .be   (be),
    .idx  (word_idx[IDX_W-1:0]),
    .wdata(wrep),
    .rd_en(accept),
    .rdata(rd_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      lane_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        write_q <= req_write;
        err_q   <= req_err;
        sgn_q   <= req_signed;
        size_q  <= sz;
        lane_q  <= lane;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Response is built from the registered read word and the latched request
  // fields, so it stays stable for as long as resp_valid is held.
  always_comb begin
    sh   = rd_word >> {lane_q, 3'b000};
    load = sh;
    case (size_q)
      SZ_BYTE: begin
        load      = (sgn_q && sh[7]) ? '1 : '0;
        load[7:0] = sh[7:0];
      end
      SZ_HALF: begin
        load       = (sgn_q && sh[15]) ? '1 : '0;
        load[15:0] = sh[15:0];
      end
      default: load = sh;
    endcase
    resp_rdata = (state == RESP && !write_q && !err_q) ? load : '0;
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Directed self-checking bench for dmem_hs: three instances at LATENCY 1, 4 and 2
// sharing clock, reset and request fields, each with its own valid/ready.
module tb_dmem_hs;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        req_valid  [3];
  logic        resp_ready [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] mon_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (resp_valid[2]) mon_q.push_back(resp_rdata[2]);

  dmem_hs #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dmem_hs #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .LATENCY(4)) u_l4 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  dmem_hs #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xact(input int d, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                      input logic sg, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clock);
    req_write     = wr;
    req_addr      = a;
    req_size      = sz;
    req_signed    = sg;
    req_wdata     = wd;
    req_valid[d]  = 1'b1;
    resp_ready[d] = 1'b1;
    @(posedge clock);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (resp_valid[d]) break;
    end
    rd = resp_rdata[d];
    er = resp_err[d];
  endtask

  task automatic run(input string tag, input int d, input logic wr, input logic [31:0] a,
                     input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(d, wr, a, sz, sg, wd, rd, er, lat);
    chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, hold;
    int          lat, seen, n;
    int          acc[10];

    reset = 1'b1;
    req_write = 1'b0; req_addr = '0; req_size = 2'b10; req_signed = 1'b0; req_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i]  = 1'b0;
      resp_ready[i] = 1'b1;
    end
    repeat (2) @(negedge clock);
    chk("rst_rdy",   32'(req_ready[0]),  0);
    chk("rst_vld",   32'(resp_valid[0]), 0);
    chk("rst_rdata", resp_rdata[0],      0);
    chk("rst_err",   32'(resp_err[0]),   0);
    reset = 1'b0;
    @(negedge clock);
    chk("rel_rdy", 32'(req_ready[0]), 1);

    // word store/load, latency 1
    run("w_st", 0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, 1);
    run("w_ld", 0, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 1);

    // sub-word lanes and extension
    run("z_st",  0, 1, 32'h20, 2'b10, 0, 32'h0,  32'h0, 0, 1);
    run("b_st",  0, 1, 32'h21, 2'b00, 0, 32'h80, 32'h0, 0, 1);
    run("b_lds", 0, 0, 32'h21, 2'b00, 1, 32'h0,  32'hFFFFFF80, 0, 1);
    run("b_ldu", 0, 0, 32'h21, 2'b00, 0, 32'h0,  32'h00000080, 0, 1);
    run("b_ldw", 0, 0, 32'h20, 2'b10, 0, 32'h0,  32'h00008000, 0, 1);
    run("h_st",  0, 1, 32'h22, 2'b01, 0, 32'h8001, 32'h0, 0, 1);
    run("h_lds", 0, 0, 32'h22, 2'b01, 1, 32'h0,  32'hFFFF8001, 0, 1);
    run("h_ldu", 0, 0, 32'h22, 2'b01, 0, 32'h0,  32'h00008001, 0, 1);
    run("h_ldw", 0, 0, 32'h20, 2'b10, 0, 32'h0,  32'h80018000, 0, 1);

    // errors
    run("e_half", 0, 0, 32'h03,  2'b01, 0, 32'h0, 32'h0, 1, 1);
    run("e_w0st", 0, 1, 32'h00,  2'b10, 0, 32'h11223344, 32'h0, 0, 1);
    run("e_rng",  0, 1, 32'h200, 2'b10, 0, 32'hFFFFFFFF, 32'h0, 1, 1);
    run("e_mis",  0, 1, 32'h02,  2'b10, 0, 32'hFFFFFFFF, 32'h0, 1, 1);
    run("e_w0ld", 0, 0, 32'h00,  2'b10, 0, 32'h0, 32'h11223344, 0, 1);
    run("e_size", 0, 0, 32'h00,  2'b11, 0, 32'h0, 32'h0, 1, 1);

    // latency 4 and backpressure
    run("l4_st",  1, 1, 32'h30, 2'b10, 0, 32'hA5A5A5A5, 32'h0, 0, 4);
    run("l4_st2", 1, 1, 32'h34, 2'b10, 0, 32'h0BADF00D, 32'h0, 0, 4);
    @(negedge clock);
    req_write = 1'b0; req_addr = 32'h30; req_size = 2'b10; req_signed = 1'b0;
    req_valid[1] = 1'b1; resp_ready[1] = 1'b0;
    @(posedge clock);
    #1 req_write = 1'b1; req_addr = 32'h34; req_wdata = 32'hFFFFFFFF;
    lat = 0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (resp_valid[1]) break;
    end
    chk("bp_lat", lat, 4);
    hold = resp_rdata[1];
    chk("bp_rd", hold, 32'hA5A5A5A5);
    repeat (3) begin
      @(negedge clock);
      chk("bp_hold", resp_rdata[1], 32'hA5A5A5A5);
      chk("bp_err", 32'(resp_err[1]), 0);
      chk("bp_rdy", 32'(req_ready[1]), 0);
      chk("bp_vld", 32'(resp_valid[1]), 1);
    end
    req_valid[1] = 1'b0; resp_ready[1] = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_done_vld", 32'(resp_valid[1]), 0);
    chk("bp_done_rdy", 32'(req_ready[1]), 1);
    run("bp_ign", 1, 0, 32'h34, 2'b10, 0, 32'h0, 32'h0BADF00D, 0, 4);

    // reset while waiting
    @(negedge clock);
    req_write = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'h12345678;
    req_valid[1] = 1'b1;
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mr_rdy",   32'(req_ready[1]),  0);
    chk("mr_vld",   32'(resp_valid[1]), 0);
    chk("mr_rdata", resp_rdata[1],      0);
    chk("mr_err",   32'(resp_err[1]),   0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mr_rel_rdy", 32'(req_ready[1]), 1);
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (resp_valid[1]) seen++;
    end
    chk("mr_noresp", seen, 0);
    run("mr_ld", 1, 0, 32'h40, 2'b10, 0, 32'h0, 32'h12345678, 0, 4);

    // back-to-back, latency 2, resp_ready high
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      req_write = (i % 2 == 0);
      req_addr  = 32'h50 + 32'(4 * (i / 2));
      req_size  = 2'b10;
      req_signed = 1'b0;
      req_wdata = 32'h10000000 + 32'(i * 257);
      req_valid[2] = 1'b1;
      n = 0;
      while (!req_ready[2] && n < 10) begin
        @(negedge clock);
        n++;
      end
      acc[i] = cyc;
      @(negedge clock);
    end
    req_valid[2] = 1'b0;
    repeat (5) @(negedge clock);
    for (int i = 1; i < 10; i++) chk("b2b_gap", acc[i] - acc[i-1], 3);
    chk("b2b_cnt", mon_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < mon_q.size()) begin
        rd = (i % 2 == 0) ? 32'h0 : 32'h10000000 + 32'((i - 1) * 257);
        chk("b2b_rd", mon_q[i], rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
